// File: rtl/branch_station_if.sv
// Issue/CDB/resolution signal bundle for the branch reservation station.
// The issue stage and the CDB drive it as master; the station is the slave.
interface branch_station_if;
    logic        br_issue;
    logic        br_cond;
    logic        br_pred;
    logic [4:0]  br_Qj;
    logic [4:0]  br_Qk;
    logic [31:0] br_Vj;
    logic [31:0] br_Vk;
    logic [31:0] br_target;
    logic [31:0] br_pc4;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        full;
    logic        busy_Q;
    logic        rollback;
    logic [31:0] rollback_pc;
    logic        resolve;

    modport master (
        output br_issue, br_cond, br_pred, br_Qj, br_Qk, br_Vj, br_Vk,
               br_target, br_pc4, cdb_valid, cdb_tag, cdb_data,
        input  full, busy_Q, rollback, rollback_pc, resolve
    );

    modport slave (
        input  br_issue, br_cond, br_pred, br_Qj, br_Qk, br_Vj, br_Vk,
               br_target, br_pc4, cdb_valid, cdb_tag, cdb_data,
        output full, busy_Q, rollback, rollback_pc, resolve
    );
endinterface

// File: rtl/branch_station.sv
// Four-entry in-order branch reservation station: snoops the CDB for operands,
// resolves the head branch one cycle after it becomes ready, flushes on mispredict.
module branch_station (
    input  logic            clk,
    input  logic            rst,
    branch_station_if.slave bus
);
    typedef struct packed {
        logic        cond;
        logic        pred;
        logic [4:0]  qj;
        logic [4:0]  qk;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] target;
        logic [31:0] pc4;
    } entry_t;

    entry_t      ent_q [4];
    entry_t      ent_d [4];
    logic [3:0]  valid_q, valid_d;
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic [2:0]  count_q, count_d;
    logic        resolve_q, resolve_d;
    logic        rollback_q, rollback_d;
    logic [31:0] rollback_pc_q, rollback_pc_d;

    logic        full;
    logic        issue_ok;
    logic        cdb_hit;
    logic        head_ready;
    logic        taken;
    logic        mispredict;
    entry_t      head;
    entry_t      new_ent;
    logic [3:0]  tag_pending;

    assign full       = (count_q == 3'd4);
    assign issue_ok   = bus.br_issue && !full;
    assign cdb_hit    = bus.cdb_valid && (bus.cdb_tag != 5'd0);
    assign head       = ent_q[head_q];
    assign head_ready = valid_q[head_q] && (head.qj == 5'd0) && (head.qk == 5'd0);
    assign taken      = (head.vj == head.vk) ^ head.cond;
    assign mispredict = (taken != head.pred);

    // Incoming entry with same-cycle CDB forwarding so no broadcast is missed.
    always_comb begin
        new_ent.cond   = bus.br_cond;
        new_ent.pred   = bus.br_pred;
        new_ent.qj     = bus.br_Qj;
        new_ent.qk     = bus.br_Qk;
        new_ent.vj     = bus.br_Vj;
        new_ent.vk     = bus.br_Vk;
        new_ent.target = bus.br_target;
        new_ent.pc4    = bus.br_pc4;
        if (cdb_hit && (bus.br_Qj == bus.cdb_tag)) begin
            new_ent.qj = 5'd0;
            new_ent.vj = bus.cdb_data;
        end
        if (cdb_hit && (bus.br_Qk == bus.cdb_tag)) begin
            new_ent.qk = 5'd0;
            new_ent.vk = bus.cdb_data;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default before any branch, so no latch is inferred.
        ent_d         = ent_q;
        valid_d       = valid_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        resolve_d     = 1'b0;
        rollback_d    = 1'b0;
        rollback_pc_d = 32'd0;

        for (int i = 0; i < 4; i++) begin
            if (cdb_hit && valid_q[i]) begin
                if (ent_q[i].qj == bus.cdb_tag) begin
                    ent_d[i].qj = 5'd0;
                    ent_d[i].vj = bus.cdb_data;
                end
                if (ent_q[i].qk == bus.cdb_tag) begin
                    ent_d[i].qk = 5'd0;
                    ent_d[i].vk = bus.cdb_data;
                end
            end
        end

        if (issue_ok) begin
            ent_d[tail_q]   = new_ent;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 2'd1;
            count_d         = count_q + 3'd1;
        end

        // Flush overrides the issue above: a mispredict discards everything, including it.
        if (head_ready) begin
            resolve_d = 1'b1;
            if (mispredict) begin
                rollback_d    = 1'b1;
                rollback_pc_d = taken ? head.target : head.pc4;
                valid_d       = 4'd0;
                head_d        = tail_q;
                tail_d        = tail_q;
                count_d       = 3'd0;
            end else begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + 2'd1;
                count_d         = count_d - 3'd1;
            end
        end
    end

    // NOTE: state registers take non-blocking assignments; the combinational block above uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= 4'd0;
            head_q        <= 2'd0;
            tail_q        <= 2'd0;
            count_q       <= 3'd0;
            resolve_q     <= 1'b0;
            rollback_q    <= 1'b0;
            rollback_pc_q <= 32'd0;
        end else begin
            valid_q       <= valid_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            resolve_q     <= resolve_d;
            rollback_q    <= rollback_d;
            rollback_pc_q <= rollback_pc_d;
        end
    end

    // NOTE: entry payload is not reset; valid_q alone decides whether a slot means anything.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tag_pending[i] = valid_q[i] && ((ent_q[i].qj != 5'd0) || (ent_q[i].qk != 5'd0));
        end
    end

    assign bus.full        = full;
    assign bus.busy_Q      = |tag_pending;
    assign bus.resolve     = resolve_q;
    assign bus.rollback    = rollback_q;
    assign bus.rollback_pc = rollback_pc_q;
endmodule

// File: tb/tb_branch_station.sv
// Randomized scoreboard bench for branch_station: a queue-based reference model
// predicts each resolution; a negedge monitor compares whatever the DUT presents.
module tb_branch_station;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_station_if bus ();

    branch_station dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit        cond;
        bit        pred;
        bit [4:0]  qj;
        bit [4:0]  qk;
        bit [31:0] vj;
        bit [31:0] vk;
        bit [31:0] tgt;
        bit [31:0] pc4;
    } br_t;

    typedef struct {
        int        cyc;
        bit        rb;
        bit [31:0] pc;
    } exp_t;

    br_t  mq[$];
    br_t  nq[$];
    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, want);
        end
    endtask

    // Reference: an ordered list of branches; the oldest resolves one cycle after its tags clear.
    function automatic void model_step();
        bit   ready;
        bit   taken;
        bit   rb;
        br_t  b;
        exp_t e;
        nq = mq;
        if (rst) begin
            nq.delete();
            return;
        end
        ready = (mq.size() > 0) && (mq[0].qj == 0) && (mq[0].qk == 0);
        if (bus.cdb_valid && bus.cdb_tag != 0) begin
            foreach (nq[i]) begin
                if (nq[i].qj == bus.cdb_tag) begin nq[i].qj = 0; nq[i].vj = bus.cdb_data; end
                if (nq[i].qk == bus.cdb_tag) begin nq[i].qk = 0; nq[i].vk = bus.cdb_data; end
            end
        end
        if (bus.br_issue && mq.size() < 4) begin
            b = '{bus.br_cond, bus.br_pred, bus.br_Qj, bus.br_Qk, bus.br_Vj, bus.br_Vk,
                  bus.br_target, bus.br_pc4};
            if (bus.cdb_valid && bus.cdb_tag != 0 && b.qj == bus.cdb_tag) begin b.qj = 0; b.vj = bus.cdb_data; end
            if (bus.cdb_valid && bus.cdb_tag != 0 && b.qk == bus.cdb_tag) begin b.qk = 0; b.vk = bus.cdb_data; end
            nq.push_back(b);
        end
        if (ready) begin
            taken = (mq[0].vj == mq[0].vk) ? !mq[0].cond : mq[0].cond;
            rb    = (taken != mq[0].pred);
            e.cyc = cyc + 1;
            e.rb  = rb;
            e.pc  = rb ? (taken ? mq[0].tgt : mq[0].pc4) : 32'd0;
            sb.push_back(e);
            if (rb) nq.delete();
            else    void'(nq.pop_front());
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        mq = nq;
    endtask

    task automatic drive_idle();
        bus.br_issue  = 1'b0;
        bus.br_cond   = 1'b0;
        bus.br_pred   = 1'b0;
        bus.br_Qj     = 5'd0;
        bus.br_Qk     = 5'd0;
        bus.br_Vj     = 32'd0;
        bus.br_Vk     = 32'd0;
        bus.br_target = 32'd0;
        bus.br_pc4    = 32'd0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = 5'd0;
        bus.cdb_data  = 32'd0;
    endtask

    task automatic set_issue(input bit cond, input bit pred, input bit [4:0] qj, input bit [4:0] qk,
                             input bit [31:0] vj, input bit [31:0] vk,
                             input bit [31:0] tgt, input bit [31:0] pc4);
        bus.br_issue  = 1'b1;
        bus.br_cond   = cond;
        bus.br_pred   = pred;
        bus.br_Qj     = qj;
        bus.br_Qk     = qk;
        bus.br_Vj     = vj;
        bus.br_Vk     = vk;
        bus.br_target = tgt;
        bus.br_pc4    = pc4;
    endtask

    task automatic set_cdb(input bit v, input bit [4:0] tag, input bit [31:0] data);
        bus.cdb_valid = v;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    function automatic bit [4:0] rand_tag();
        return ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
    endfunction

    // Monitor: flags and status every cycle, resolutions against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   busy;
            exp_t e;
            busy = 1'b0;
            foreach (mq[i]) if (mq[i].qj != 0 || mq[i].qk != 0) busy = 1'b1;
            check("full", bus.full, 32'(mq.size() == 4));
            check("busy_Q", bus.busy_Q, 32'(busy));
            if (bus.resolve === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_resolve at cycle %0d: got resolve=1, want none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("resolve_cycle", cyc, e.cyc);
                    check("rollback", bus.rollback, 32'(e.rb));
                    check("rollback_pc", bus.rollback_pc, e.pc);
                end
            end else begin
                check("rollback_idle", bus.rollback, 32'd0);
                check("rollback_pc_idle", bus.rollback_pc, 32'd0);
            end
        end
    end

    initial begin
        drive_idle();
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;

        // beq with equal ready operands, predicted taken: clean resolve.
        set_issue(1'b0, 1'b1, 5'd0, 5'd0, 32'd5, 32'd5, 32'h200, 32'h204);
        tick();
        drive_idle();
        repeat (3) tick();

        // bne waiting on tag 3; CDB delivers a differing value -> taken mispredict to target.
        set_issue(1'b1, 1'b0, 5'd0, 5'd3, 32'd7, 32'd0, 32'h100, 32'h44);
        tick();
        drive_idle();
        set_cdb(1'b1, 5'd3, 32'd9);
        tick();
        drive_idle();
        repeat (3) tick();

        // Fill all four slots on tag 2, a fifth issue is dropped, then release them in order.
        repeat (5) begin
            set_issue(1'b0, 1'b1, 5'd2, 5'd0, 32'd1, 32'd1, 32'h300, 32'h304);
            tick();
        end
        drive_idle();
        set_cdb(1'b1, 5'd2, 32'd1);
        tick();
        drive_idle();
        repeat (6) tick();

        // Issue coinciding with its own producer's broadcast.
        set_issue(1'b0, 1'b1, 5'd0, 5'd4, 32'd1, 32'd0, 32'h400, 32'h404);
        set_cdb(1'b1, 5'd4, 32'd1);
        tick();
        drive_idle();
        repeat (3) tick();

        // Two pending, head mispredicts while a new issue is offered.
        set_issue(1'b0, 1'b0, 5'd5, 5'd0, 32'd1, 32'd2, 32'h500, 32'h504);
        tick();
        set_issue(1'b0, 1'b1, 5'd0, 5'd0, 32'd3, 32'd3, 32'h600, 32'h604);
        tick();
        drive_idle();
        set_cdb(1'b1, 5'd5, 32'd2);
        tick();
        drive_idle();
        set_issue(1'b0, 1'b1, 5'd0, 5'd0, 32'd8, 32'd8, 32'h700, 32'h704);
        tick();
        drive_idle();
        repeat (3) tick();

        // Reset while the head is ready.
        set_issue(1'b1, 1'b1, 5'd0, 5'd0, 32'd1, 32'd2, 32'h800, 32'h804);
        tick();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Random traffic.
        repeat (3000) begin
            rst = ($urandom_range(0, 79) == 0);
            drive_idle();
            if ($urandom_range(0, 1) == 1)
                set_issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_tag(), rand_tag(),
                          $urandom_range(0, 2), $urandom_range(0, 2), $urandom, $urandom);
            if ($urandom_range(0, 1) == 1)
                set_cdb(1'b1, 5'($urandom_range(0, 6)), $urandom_range(0, 2));
            tick();
        end

        // Drain: broadcast every tag in use so all waiting entries resolve.
        rst = 1'b0;
        drive_idle();
        for (int t = 1; t <= 6; t++) begin
            set_cdb(1'b1, 5'(t), $urandom_range(0, 2));
            tick();
        end
        drive_idle();
        repeat (10) tick();

        check("scoreboard_empty", sb.size(), 32'd0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_station.md
BRANCH_STATION -- requirements
Module: branch_station

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port br_issue  input  1  issue valid for a conditional branch.
REQ-004 SHALL have port br_cond  input  1  0 = beq (taken if Vj==Vk), 1 = bne (taken if Vj!=Vk).
REQ-005 SHALL have port br_pred  input  1  predicted taken flag from fetch.
REQ-006 SHALL have ports br_Qj, br_Qk  input  5 each  producer tags; 0 = operand already valid.
REQ-007 SHALL have ports br_Vj, br_Vk  input  32 each  operand values, meaningful only when matching tag is 0.
REQ-008 SHALL have ports br_target, br_pc4  input  32 each  taken target and fall-through PC.
REQ-009 SHALL have ports cdb_valid (1), cdb_tag (5), cdb_data (32)  input  common data bus broadcast.
REQ-010 SHALL have port full  output  1  no free entry; issue stage stalls.
REQ-011 SHALL have port busy_Q  output  1  at least one entry holds a non-zero tag.
REQ-012 SHALL have port rollback  output  1  one-cycle mispredict pulse.
REQ-013 SHALL have port rollback_pc  output  32  corrected fetch PC, valid while rollback=1.
REQ-014 SHALL have port resolve  output  1  one-cycle pulse each time the head branch retires (correct or not).

Function
REQ-015 SHALL hold 4 entries in a circular FIFO (2-bit head/tail pointers, 3-bit count), resolving strictly in issue order.
REQ-016 SHALL assert full combinationally when count==4; br_issue while full SHALL be ignored (no write, no pointer change).
REQ-017 SHALL on accepted issue write cond, pred, Qj/Qk, Vj/Vk, target, pc4 at tail and advance tail (wrap 3->0).
REQ-018 SHALL on cdb_valid, for every valid entry with Qj==cdb_tag (tag!=0), load Vj=cdb_data and clear Qj; same for Qk.
REQ-019 SHALL apply the CDB match to the entry being issued in the same cycle (issue tags compared against cdb_tag before writing), so the operand is captured and the tag cleared.
REQ-020 SHALL consider the head ready when valid with Qj==0 and Qk==0 at the start of a cycle; resolve is registered, asserting on the next edge (one-cycle latency from readiness).
REQ-021 SHALL compute taken = (Vj==Vk) XOR cond; mispredict = taken != pred.
REQ-022 SHALL, on resolve without mispredict, pulse resolve, pop head (head+1, count-1), rollback=0.
REQ-023 SHALL, on resolve with mispredict, pulse resolve and rollback together, drive rollback_pc = taken ? target : pc4, and invalidate all entries (head=tail, count=0).
REQ-024 SHALL give flush priority over issue: a br_issue in the cycle rollback is being registered SHALL be discarded.
REQ-025 SHALL, on simultaneous non-flushing resolve and issue with count==4, reject the issue (full evaluated before pop); with count<4 both SHALL occur and count stays constant.
REQ-026 SHALL resolve at most one branch per cycle; rollback SHALL never be asserted two consecutive cycles.
REQ-027 SHALL drive rollback_pc = 0 when rollback = 0.
REQ-028 SHALL compute busy_Q combinationally from valid entries' tags.

Reset
REQ-029 SHALL on rst=1 at a clock edge clear all valid bits, head=tail=count=0, rollback=0, resolve=0, rollback_pc=0; full=0 and busy_Q=0 the following cycle.
REQ-030 SHALL take rst priority over issue, CDB and resolve in the same cycle, including mid-resolution.

Verification
REQ-031 Issue beq Qj=Qk=0, Vj=Vk=5, pred=1 -> resolve=1 two edges later, rollback=0, count returns 0.
REQ-032 Issue bne Qj=0, Qk=3, Vj=7, pred=0, target=0x100, pc4=0x44; next cycle cdb_tag=3, data=9 -> resolve and rollback=1, rollback_pc=0x100, count=0.
REQ-033 Issue 4 branches with Qj=2 -> full=1; 5th issue ignored; cdb_tag=2 -> branches resolve one per cycle in order, full drops after first pop.
REQ-034 Issue with Qk=4 in same cycle as cdb_tag=4, data=1 -> entry stored with Qk=0, Vk=1, resolves one cycle later.
REQ-035 Two entries pending, head mispredicts while br_issue=1 -> rollback=1, count=0, new issue discarded.
REQ-036 Assert rst while head ready -> no resolve/rollback pulse, all outputs 0 next cycle.
